multicycle_controller: RTL

Multi-cycle successor to the single-cycle main decoder. It sequences each RV32 instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the same datapath control set as the single-cycle decoder, plus phase strobes. It adds req/ready handshakes to instruction and data memory, a memory-stall timeout, and illegal-opcode trapping. It sits between the instruction register and the multi-cycle datapath.

---
 rtl/multicycle_controller_if.sv | 13 +
 rtl/multicycle_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle for multicycle_controller: instruction and data
// memory request/ready pairs. The controller takes the master side.
interface multicycle_controller_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;

  modport master (output imem_req, output dmem_req,
                  input  imem_ready, input dmem_ready);
  modport slave  (input  imem_req, input  dmem_req,
                  output imem_ready, output dmem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: sequences RV32 instructions through
// BOOT/FETCH/DECODE/EXEC/MEM/WB/HALTED and drives the multi-cycle datapath
// controls, memory handshakes, a memory-stall timeout and illegal-opcode trap.
// Optional macro CTRL_PERF_CNT_EN adds cycle_cnt/instret_cnt counters
// (and the CNT_W parameter).
module multicycle_controller #(
  parameter int OPCODE_W    = 7,
  parameter int MEM_TIMEOUT = 16
`ifdef CTRL_PERF_CNT_EN
  , parameter int CNT_W     = 32
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] Opcode,
  multicycle_controller_if.master mem,
  output logic                ir_write,
  output logic                pc_write,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                Branch,
  output logic                JalrSel,
  output logic [1:0]          ALUOp,
  output logic [1:0]          RWSel,
  output logic                RegWrite,
  output logic                halted,
  output logic                illegal,
  output logic                timeout
`ifdef CTRL_PERF_CNT_EN
  , output logic [CNT_W-1:0]  cycle_cnt
  , output logic [CNT_W-1:0]  instret_cnt
`endif
);

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I    = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_JALR = OPCODE_W'(7'b1100111);
  localparam logic [OPCODE_W-1:0] OP_LUI  = OPCODE_W'(7'b0110111);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(7'b1111111);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [2:0]          state, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic [TW-1:0]       wait_cnt;
  logic                stall_limit;
  logic                set_illegal, set_timeout;
  logic                imem_req_c, dmem_req_c;
  logic                is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui;

  assign is_r    = (op_q == OP_R);
  assign is_i    = (op_q == OP_I);
  assign is_lw   = (op_q == OP_LW);
  assign is_sw   = (op_q == OP_SW);
  assign is_br   = (op_q == OP_BR);
  assign is_jal  = (op_q == OP_JAL);
  assign is_jalr = (op_q == OP_JALR);
  assign is_lui  = (op_q == OP_LUI);

  // wait_cnt holds the wait cycles already spent, so the current cycle is
  // the MEM_TIMEOUT-th one when it equals MEM_TIMEOUT-1.
  assign stall_limit = (MEM_TIMEOUT > 0) && (wait_cnt == TW'(MEM_TIMEOUT - 1));

  assign mem.imem_req = imem_req_c;
  assign mem.dmem_req = dmem_req_c;
  assign halted       = (state == S_HALTED);

  // Next-state selection, phase strobes and decode outputs from op_q
  always_comb begin
    state_d     = state;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    imem_req_c  = 1'b0;
    dmem_req_c  = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrc      = 1'b0;
    MemtoReg    = 1'b0;
    Branch      = 1'b0;
    JalrSel     = 1'b0;
    ALUOp       = '0;
    RWSel       = '0;
    case (state)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (mem.imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (stall_limit) begin
          set_timeout = 1'b1;
          state_d     = S_HALTED;
        end
      end
      S_DECODE: begin
        case (Opcode)
          OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI:
            state_d = S_EXEC;
          OP_HALT: state_d = S_HALTED;
          default: begin
            set_illegal = 1'b1;
            state_d     = S_HALTED;
          end
        endcase
      end
      S_EXEC: begin
        if (is_br) begin
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        MemRead    = is_lw;
        MemWrite   = is_sw;
        if (mem.dmem_ready) begin
          pc_write = is_sw;
          state_d  = is_sw ? S_FETCH : S_WB;
        end else if (stall_limit) begin
          set_timeout = 1'b1;
          state_d     = S_HALTED;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_BOOT;
    endcase
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      ALUSrc   = is_lw | is_sw | is_i | is_jalr;
      MemtoReg = is_lw;
      ALUOp    = {is_r | is_i | is_jal | is_lui, is_br | is_jal | is_lui};
      Branch   = is_br | is_jal;
      JalrSel  = is_jalr;
      RWSel    = {is_lui, is_jal | is_jalr};
    end
  end

  // State register, opcode capture, stall counter and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      op_q     <= '0;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state <= state_d;
      if (state == S_DECODE) op_q <= Opcode;
      // Leaving or completing a wait clears the count, so each FETCH/MEM entry starts at zero
      if ((state == S_FETCH && !mem.imem_ready) || (state == S_MEM && !mem.dmem_ready))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (set_illegal) illegal <= 1'b1;
      if (set_timeout) timeout <= 1'b1;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  // Active-cycle and retired-instruction counters, frozen in BOOT/HALTED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_BOOT && state != S_HALTED) cycle_cnt <= cycle_cnt + 1'b1;
      if (pc_write) instret_cnt <= instret_cnt + 1'b1;
    end
  end
`endif

endmodule
